// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter with valid/ready input, a one-word holding
// buffer for gapless streaming, frame markers and a bit-strobe enable.
module piso_serializer #(
    parameter int unsigned N         = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter logic        IDLE_VAL  = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] p_in,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         en,
    output logic         s_out,
    output logic         s_valid,
    output logic         s_first,
    output logic         s_last,
    output logic         busy
);

    localparam int unsigned     CW   = $clog2(N);
    localparam logic [CW-1:0]   LAST = CW'(N - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   sreg_q, sreg_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   hold_q, hold_d;
    logic           hold_full_q, hold_full_d;

    logic           active;
    logic           at_last;
    logic           xfer;
    logic [N-1:0]   sreg_shifted;

    assign active   = (state_q == ST_SHIFT);
    assign at_last  = (cnt_q == LAST);
    assign in_ready = ~hold_full_q;
    assign xfer     = in_valid & ~hold_full_q;

    assign sreg_shifted = MSB_FIRST ? {sreg_q[N-2:0], 1'b0} : {1'b0, sreg_q[N-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sreg_q      <= '0;
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;

        if (active && en) begin
            if (!at_last) begin
                sreg_d = sreg_shifted;
                cnt_d  = cnt_q + CW'(1);
            end else begin
                cnt_d = '0;
                if (hold_full_q) begin
                    sreg_d      = hold_q;
                    hold_full_d = 1'b0;
                end else if (xfer) begin
                    sreg_d = p_in;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        end

        // On the retiring edge an incoming word was already placed in sreg above;
        // otherwise it starts the shifter when idle or waits in hold.
        if (xfer) begin
            if (!active) begin
                sreg_d  = p_in;
                cnt_d   = '0;
                state_d = ST_SHIFT;
            end else if (!(en && at_last)) begin
                hold_d      = p_in;
                hold_full_d = 1'b1;
            end
        end
    end

    assign s_valid = active;
    assign s_out   = active ? (MSB_FIRST ? sreg_q[N-1] : sreg_q[0]) : IDLE_VAL;
    assign s_first = active & (cnt_q == '0);
    assign s_last  = active & at_last;
    assign busy    = active | hold_full_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: MSB/LSB-first words, streaming through
// the holding buffer, en stalls, mid-word reset and the N=2 boundary.
module tb_piso_serializer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // u_m: N=8 MSB-first, IDLE 0
    logic [7:0] p_in_m = '0;
    logic in_valid_m = 1'b0;
    logic in_ready_m, s_out_m, s_valid_m, s_first_m, s_last_m, busy_m;
    // u_l: N=8 LSB-first, IDLE 1
    logic [7:0] p_in_l = '0;
    logic in_valid_l = 1'b0;
    logic in_ready_l, s_out_l, s_valid_l, s_first_l, s_last_l, busy_l;
    // u_t: N=2 MSB-first, IDLE 0
    logic [1:0] p_in_t = '0;
    logic in_valid_t = 1'b0;
    logic in_ready_t, s_out_t, s_valid_t, s_first_t, s_last_t, busy_t;

    piso_serializer #(.N(8), .MSB_FIRST(1'b1), .IDLE_VAL(1'b0)) u_m (
        .clk(clk), .rst(rst), .p_in(p_in_m), .in_valid(in_valid_m), .in_ready(in_ready_m),
        .en(en), .s_out(s_out_m), .s_valid(s_valid_m), .s_first(s_first_m),
        .s_last(s_last_m), .busy(busy_m)
    );

    piso_serializer #(.N(8), .MSB_FIRST(1'b0), .IDLE_VAL(1'b1)) u_l (
        .clk(clk), .rst(rst), .p_in(p_in_l), .in_valid(in_valid_l), .in_ready(in_ready_l),
        .en(en), .s_out(s_out_l), .s_valid(s_valid_l), .s_first(s_first_l),
        .s_last(s_last_l), .busy(busy_l)
    );

    piso_serializer #(.N(2), .MSB_FIRST(1'b1), .IDLE_VAL(1'b0)) u_t (
        .clk(clk), .rst(rst), .p_in(p_in_t), .in_valid(in_valid_t), .in_ready(in_ready_t),
        .en(en), .s_out(s_out_t), .s_valid(s_valid_t), .s_first(s_first_t),
        .s_last(s_last_t), .busy(busy_t)
    );

    // Observation tuple: {s_valid, s_out, s_first, s_last, busy, in_ready}
    task automatic test_reset;
        logic [5:0] obs;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        obs = {s_valid_m, s_out_m, s_first_m, s_last_m, busy_m, in_ready_m};
        checks++;
        if (obs !== 6'b000001) begin
            errors++;
            $display("FAIL reset_msb got %b expected %b", obs, 6'b000001);
        end
        obs = {s_valid_l, s_out_l, s_first_l, s_last_l, busy_l, in_ready_l};
        checks++;
        if (obs !== 6'b010001) begin
            errors++;
            $display("FAIL reset_lsb got %b expected %b", obs, 6'b010001);
        end
        obs = {s_valid_t, s_out_t, s_first_t, s_last_t, busy_t, in_ready_t};
        checks++;
        if (obs !== 6'b000001) begin
            errors++;
            $display("FAIL reset_n2 got %b expected %b", obs, 6'b000001);
        end
        rst = 1'b0;
    endtask

    task automatic test_msb_first;
        logic [7:0] seq = 8'b0001_1110;
        logic [5:0] obs, exp;
        @(negedge clk);
        p_in_m = 8'h1E; in_valid_m = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid_m = 1'b0;
            obs = {s_valid_m, s_out_m, s_first_m, s_last_m, busy_m, in_ready_m};
            exp = {1'b1, seq[7-i], (i == 0), (i == 7), 1'b1, 1'b1};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL msb_first bit %0d got %b expected %b", i, obs, exp);
            end
        end
        @(negedge clk);
        obs = {s_valid_m, s_out_m, s_first_m, s_last_m, busy_m, in_ready_m};
        checks++;
        if (obs !== 6'b000001) begin
            errors++;
            $display("FAIL msb_first_idle got %b expected %b", obs, 6'b000001);
        end
    endtask

    task automatic test_lsb_first;
        logic [7:0] seq = 8'b0111_1000;
        logic [5:0] obs, exp;
        @(negedge clk);
        p_in_l = 8'h1E; in_valid_l = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid_l = 1'b0;
            obs = {s_valid_l, s_out_l, s_first_l, s_last_l, busy_l, in_ready_l};
            exp = {1'b1, seq[7-i], (i == 0), (i == 7), 1'b1, 1'b1};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL lsb_first bit %0d got %b expected %b", i, obs, exp);
            end
        end
        @(negedge clk);
        obs = {s_valid_l, s_out_l, s_first_l, s_last_l, busy_l, in_ready_l};
        checks++;
        if (obs !== 6'b010001) begin
            errors++;
            $display("FAIL lsb_first_idle got %b expected %b", obs, 6'b010001);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] seq = 16'b0001_1110_1100_0011;
        logic [5:0] obs, exp;
        @(negedge clk);
        p_in_m = 8'h1E; in_valid_m = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            in_valid_m = 1'b0;
            obs = {s_valid_m, s_out_m, s_first_m, s_last_m, busy_m, in_ready_m};
            exp = {1'b1, seq[15-i], (i % 8 == 0), (i % 8 == 7), 1'b1, (i == 0 || i >= 8)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL back_to_back bit %0d got %b expected %b", i, obs, exp);
            end
            if (i == 0) begin
                p_in_m = 8'hC3; in_valid_m = 1'b1;
            end
        end
        @(negedge clk);
        obs = {s_valid_m, s_out_m, s_first_m, s_last_m, busy_m, in_ready_m};
        checks++;
        if (obs !== 6'b000001) begin
            errors++;
            $display("FAIL back_to_back_idle got %b expected %b", obs, 6'b000001);
        end
    endtask

    task automatic test_stall;
        logic [7:0] seq = 8'hA5;
        logic [5:0] obs, exp;
        @(negedge clk);
        p_in_m = 8'hA5; in_valid_m = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid_m = 1'b0;
            obs = {s_valid_m, s_out_m, s_first_m, s_last_m, busy_m, in_ready_m};
            exp = {1'b1, seq[7-i], (i == 0), (i == 7), 1'b1, 1'b1};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL stall bit %0d got %b expected %b", i, obs, exp);
            end
            if (i == 2) begin
                en = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    obs = {s_valid_m, s_out_m, s_first_m, s_last_m, busy_m, in_ready_m};
                    checks++;
                    if (obs !== exp) begin
                        errors++;
                        $display("FAIL stall_frozen cycle %0d got %b expected %b", s, obs, exp);
                    end
                end
                en = 1'b1;
            end
        end
        @(negedge clk);
        obs = {s_valid_m, s_out_m, s_first_m, s_last_m, busy_m, in_ready_m};
        checks++;
        if (obs !== 6'b000001) begin
            errors++;
            $display("FAIL stall_idle got %b expected %b", obs, 6'b000001);
        end
    endtask

    task automatic test_reset_mid_word;
        logic [7:0] seq_a = 8'h5A;
        logic [7:0] seq_b = 8'h81;
        logic [5:0] obs, exp;
        @(negedge clk);
        p_in_m = 8'h5A; in_valid_m = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid_m = 1'b0;
            obs = {s_valid_m, s_out_m, s_first_m, s_last_m, busy_m, in_ready_m};
            exp = {1'b1, seq_a[7-i], (i == 0), 1'b0, 1'b1, (i == 0)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL rst_mid_pre bit %0d got %b expected %b", i, obs, exp);
            end
            if (i == 0) begin
                p_in_m = 8'h3C; in_valid_m = 1'b1;
            end
        end
        rst = 1'b1;
        #1;
        obs = {s_valid_m, s_out_m, s_first_m, s_last_m, busy_m, in_ready_m};
        checks++;
        if (obs !== 6'b000001) begin
            errors++;
            $display("FAIL rst_mid_immediate got %b expected %b", obs, 6'b000001);
        end
        @(negedge clk);
        rst = 1'b0;
        p_in_m = 8'h81; in_valid_m = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid_m = 1'b0;
            obs = {s_valid_m, s_out_m, s_first_m, s_last_m, busy_m, in_ready_m};
            exp = {1'b1, seq_b[7-i], (i == 0), (i == 7), 1'b1, 1'b1};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL rst_mid_reload bit %0d got %b expected %b", i, obs, exp);
            end
        end
        @(negedge clk);
        obs = {s_valid_m, s_out_m, s_first_m, s_last_m, busy_m, in_ready_m};
        checks++;
        if (obs !== 6'b000001) begin
            errors++;
            $display("FAIL rst_mid_idle got %b expected %b", obs, 6'b000001);
        end
    endtask

    task automatic test_n2_stream;
        logic [1:0] words [3] = '{2'b10, 2'b01, 2'b11};
        logic [5:0] bits = 6'b100111;
        logic [3:0] obs, exp;
        int idx = 0;
        @(negedge clk);
        p_in_t = words[0]; in_valid_t = 1'b1;
        if (in_ready_t) idx = 1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            obs = {s_valid_t, s_out_t, s_first_t, s_last_t};
            if (c < 6) exp = {1'b1, bits[5-c], (c % 2 == 0), (c % 2 == 1)};
            else       exp = 4'b0000;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL n2_stream cycle %0d got %b expected %b", c, obs, exp);
            end
            if (idx < 3) begin
                p_in_t = words[idx]; in_valid_t = 1'b1;
                if (in_ready_t) idx++;
            end else begin
                in_valid_t = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_back_to_back();
        test_stall();
        test_reset_mid_word();
        test_n2_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
